// File: rtl/display_output_controller.sv
// -----------------------------------------------------------------------------
// display_output_controller
//
// Consumer side of the memory-mapped text display. Each CPU write to the
// display data register delivers one character. The controller renders that
// character into a COLS x ROWS character RAM. It places printable glyphs,
// moves the cursor, handles LF / CR / BS, and blanks the destination row
// whenever the cursor moves onto a new line. After reset the whole screen is
// blanked before the first character is accepted.
//
// Ports
//   Clk         system clock; all state changes happen on its rising edge
//   Reset       asynchronous, active-high; restarts the full-screen clear
//   Char_Wr     one-cycle strobe: the CPU wrote the display data register
//   Char_Data   display data register value; only [7:0] carries the character
//   Ready       1 = idle and able to take a character (status ready bit)
//   VRAM_WE     character RAM write enable (registered)
//   VRAM_Addr   character RAM address = row*COLS + col (registered)
//   VRAM_Data   character RAM write data (registered)
//   Cursor_Col  current cursor column, 0..COLS-1
//   Cursor_Row  current cursor row, 0..ROWS-1
// -----------------------------------------------------------------------------
module display_output_controller #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Char_Wr,
    input  logic [15:0]       Char_Data,
    output logic              Ready,
    output logic              VRAM_WE,
    output logic [ADDR_W-1:0] VRAM_Addr,
    output logic [7:0]        VRAM_Data,
    output logic [6:0]        Cursor_Col,
    output logic [4:0]        Cursor_Row
);

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        WRITE,
        CLEAR_LINE
    } state_t;

    // The counter is one bit wider than the address. This lets it reach
    // COLS*ROWS even when the screen exactly fills the address space.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CELLS_C  = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0] COLS_C   = CNT_W'(COLS);
    localparam logic [6:0]       LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]       LAST_ROW = 5'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    state_t           state;
    logic [CNT_W-1:0] clr_cnt;
    logic [7:0]       ch;
    logic             printable;
    logic             unused_hi;

    assign ch        = Char_Data[7:0];
    assign printable = (ch >= 8'h20) && (ch <= 8'h7E);
    // The upper byte of the data register carries nothing for the display.
    assign unused_hi = ^Char_Data[15:8];

    // Linear cell address. The operands are widened to the full address
    // width before the multiply, so row*COLS cannot be truncated.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                    input logic [6:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // There is no scrolling. The row after the last one is row 0 again.
    function automatic logic [4:0] next_row(input logic [4:0] row);
        return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= CLEAR_ALL;
            clr_cnt    <= '0;
            Cursor_Col <= '0;
            Cursor_Row <= '0;
            Ready      <= 1'b0;
            VRAM_WE    <= 1'b0;
            VRAM_Addr  <= '0;
            VRAM_Data  <= '0;
        end else begin
            case (state)
                // Blank every cell once, in ascending address order.
                CLEAR_ALL: begin
                    if (clr_cnt < CELLS_C) begin
                        VRAM_WE   <= 1'b1;
                        VRAM_Addr <= clr_cnt[ADDR_W-1:0];
                        VRAM_Data <= CLEAR_CHAR;
                        clr_cnt   <= clr_cnt + 1'b1;
                    end else begin
                        VRAM_WE <= 1'b0;
                        Ready   <= 1'b1;
                        state   <= IDLE;
                    end
                end

                // Ready is high only here. A strobe in any other state is
                // simply never looked at, so the character is dropped.
                IDLE: begin
                    VRAM_WE <= 1'b0;
                    if (Char_Wr) begin
                        Ready   <= 1'b0;
                        state   <= WRITE;
                        clr_cnt <= '0;
                        if (printable) begin
                            VRAM_WE   <= 1'b1;
                            VRAM_Addr <= cell_addr(Cursor_Row, Cursor_Col);
                            VRAM_Data <= ch;
                            if (Cursor_Col == LAST_COL) begin
                                Cursor_Col <= '0;
                                Cursor_Row <= next_row(Cursor_Row);
                                state      <= CLEAR_LINE;
                            end else begin
                                Cursor_Col <= Cursor_Col + 7'd1;
                            end
                        end else if (ch == CH_LF) begin
                            Cursor_Col <= '0;
                            Cursor_Row <= next_row(Cursor_Row);
                            state      <= CLEAR_LINE;
                        end else if (ch == CH_CR) begin
                            Cursor_Col <= '0;
                        end else if (ch == CH_BS && Cursor_Col != 7'd0) begin
                            Cursor_Col <= Cursor_Col - 7'd1;
                            VRAM_WE    <= 1'b1;
                            VRAM_Addr  <= cell_addr(Cursor_Row, Cursor_Col - 7'd1);
                            VRAM_Data  <= CLEAR_CHAR;
                        end
                        // A BS at column 0 and every other code only cost
                        // one not-ready cycle.
                    end
                end

                // Single-cycle completion of a character write or a control code.
                WRITE: begin
                    VRAM_WE <= 1'b0;
                    Ready   <= 1'b1;
                    state   <= IDLE;
                end

                // Blank the row the cursor just moved onto. The row register
                // was already advanced, so it names the destination row.
                CLEAR_LINE: begin
                    if (clr_cnt < COLS_C) begin
                        VRAM_WE   <= 1'b1;
                        VRAM_Addr <= cell_addr(Cursor_Row, clr_cnt[6:0]);
                        VRAM_Data <= CLEAR_CHAR;
                        clr_cnt   <= clr_cnt + 1'b1;
                    end else begin
                        VRAM_WE <= 1'b0;
                        Ready   <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    VRAM_WE <= 1'b0;
                    Ready   <= 1'b0;
                    clr_cnt <= '0;
                    state   <= CLEAR_ALL;
                end
            endcase
        end
    end

endmodule
